// File: rtl/countdown_timer_ctrl_if.sv
// Command/status bundle between the front-panel controller and the countdown sequencer.
// master issues 1-cycle command pulses; slave returns BCD digits and run status.
interface countdown_timer_ctrl_if;
  logic       start;
  logic       pause;
  logic       clear;
  logic       load_en;
  logic [6:0] load_val;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       sec_tick;
  logic       busy;
  logic       done;
  logic       alarm;

  modport master (
    output start, pause, clear, load_en, load_val,
    input  tens, ones, sec_tick, busy, done, alarm
  );

  modport slave (
    input  start, pause, clear, load_en, load_val,
    output tens, ones, sec_tick, busy, done, alarm
  );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// Seconds countdown sequencer: prescaler, start/pause/clear/load FSM and BCD count.
// Drives the two 7-seg digit decoders plus busy/done/alarm status.
module countdown_timer_ctrl #(
  parameter int CLK_FREQ_HZ = 100,
  parameter int MAX_COUNT   = 59
) (
  input  logic                  clk,
  input  logic                  rst_n,
  countdown_timer_ctrl_if.slave bus
);

  localparam int          PW       = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PW-1:0] PRE_TERM = PW'(CLK_FREQ_HZ - 1);
  localparam logic [6:0]  MAX7     = 7'(MAX_COUNT);
  localparam logic [7:0]  MAX_BCD  = {4'(MAX_COUNT / 10), 4'(MAX_COUNT % 10)};

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;
  typedef enum logic [1:0] {P_HOLD, P_INC, P_CLR} presc_op_t;
  typedef enum logic [1:0] {C_HOLD, C_DEC, C_LOAD, C_RELOAD} cnt_op_t;

  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  state_t        state, state_nxt;
  presc_op_t     presc_op;
  cnt_op_t       cnt_op;
  logic          reload_we;
  logic          run_step;
  logic [PW-1:0] presc;
  logic [6:0]    reload;
  logic [3:0]    tens_q, ones_q;
  logic          tick_q, done_q;

  logic [6:0]    load_sat;
  logic          cnt_zero, cnt_one, presc_term;

  assign load_sat   = (bus.load_val > MAX7) ? MAX7 : bus.load_val;
  assign cnt_zero   = (tens_q == 4'd0) && (ones_q == 4'd0);
  assign cnt_one    = (tens_q == 4'd0) && (ones_q == 4'd1);
  assign presc_term = (presc == PRE_TERM);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state and datapath strobes; clear overrides everything decided above it
  always_comb begin
    state_nxt = state;
    presc_op  = P_HOLD;
    cnt_op    = C_HOLD;
    reload_we = 1'b0;
    run_step  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load_en) begin
          reload_we = 1'b1;
          cnt_op    = C_LOAD;
        end else if (bus.start && !cnt_zero) begin
          state_nxt = RUN;
          presc_op  = P_CLR;
        end
      end
      RUN: begin
        if (bus.pause) state_nxt = PAUSE;
        else           run_step  = 1'b1;
      end
      PAUSE: begin
        // the resume edge is itself a counting cycle, so the held phase is preserved
        if (bus.start) begin
          state_nxt = RUN;
          run_step  = 1'b1;
        end
      end
      EXPIRED: begin
        if (bus.load_en) begin
          reload_we = 1'b1;
          cnt_op    = C_LOAD;
          state_nxt = IDLE;
        end else if (bus.start && (reload != 7'd0)) begin
          cnt_op    = C_RELOAD;
          presc_op  = P_CLR;
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (run_step) begin
      if (presc_term) begin
        presc_op = P_CLR;
        if (!cnt_zero) begin
          cnt_op = C_DEC;
          if (cnt_one) state_nxt = EXPIRED;
        end
      end else begin
        presc_op = P_INC;
      end
    end

    if (bus.clear) begin
      state_nxt = IDLE;
      presc_op  = P_CLR;
      cnt_op    = C_RELOAD;
      reload_we = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else begin
      case (presc_op)
        P_INC:   presc <= presc + 1'b1;
        P_CLR:   presc <= '0;
        default: presc <= presc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload <= MAX7;
    end else if (reload_we) begin
      reload <= load_sat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {tens_q, ones_q} <= MAX_BCD;
    end else begin
      case (cnt_op)
        C_DEC: begin
          if (ones_q != 4'd0) begin
            ones_q <= ones_q - 4'd1;
          end else begin
            ones_q <= 4'd9;
            tens_q <= tens_q - 4'd1;
          end
        end
        C_LOAD:   {tens_q, ones_q} <= bin2bcd(load_sat);
        C_RELOAD: {tens_q, ones_q} <= bin2bcd(reload);
        default:  ;
      endcase
    end
  end

  // status pulses land the cycle after the decrement that caused them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      tick_q <= (cnt_op == C_DEC);
      done_q <= (cnt_op == C_DEC) && cnt_one;
    end
  end

  // output decode
  always_comb begin
    bus.tens     = tens_q;
    bus.ones     = ones_q;
    bus.sec_tick = tick_q;
    bus.done     = done_q;
    bus.busy     = (state == RUN) || (state == PAUSE);
    bus.alarm    = (state == EXPIRED);
  end

endmodule
